io_bus_responder: RTL and testbench

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_bus_responder.sv | 171 +++++++++++++++++
 tb/tb_io_bus_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: a 3-cycle IDLE/BUSY/DONE handshake in front of LED, HEX,
// switch and pushbutton-edge registers.
module io_bus_responder #(
  parameter int DATA_W = 16,
  parameter int SW_W   = 10,
  parameter int LED_W  = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Ack,
  output logic              RdValid,
  output logic [DATA_W-1:0] RdData,
  input  logic [SW_W-1:0]   SW,
  input  logic [3:0]        KEY,
  output logic [LED_W-1:0]  LEDR,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [3:0]          r_page;
  logic [2:0]          r_sel;
  logic [DATA_W-1:0]   r_wdata;
  logic [SW_W-1:0]     r_sw_meta;
  logic [SW_W-1:0]     r_sw_sync;
  logic [3:0]          r_key_meta;
  logic [3:0]          r_key_sync;
  logic [3:0]          r_key_prev;
  logic [3:0]          r_edge;
  logic [LED_W-1:0]    r_ledr;
  logic [6:0]          r_seg [6];
  logic                r_ack;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_wr_en;
  logic                w_rd_en;
  logic [3:0]          w_key_press;
  logic [3:0]          w_edge_clr;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_unused;

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: the default assignment before the case keeps this block purely combinational.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Req) w_next = BUSY;
      BUSY:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr    <= 1'b0;
      r_page  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && Req) begin
      r_wr    <= Wr;
      r_page  <= Addr[15:12];
      r_sel   <= Addr[2:0];
      r_wdata <= WrData;
    end
  end

  // The access takes effect on the edge leaving BUSY, so results show up in DONE.
  assign w_wr_en = (r_state == BUSY) &&  r_wr;
  assign w_rd_en = (r_state == BUSY) && !r_wr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= 4'hF;
      r_key_sync <= 4'hF;
      r_key_prev <= 4'hF;
    end else begin
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= KEY;
      r_key_sync <= r_key_meta;
      r_key_prev <= r_key_sync;
    end
  end

  // A press is the synchronized 1->0 transition; the set term is OR-ed last so it wins a clear.
  assign w_key_press = r_key_prev & ~r_key_sync;
  assign w_edge_clr  = (w_wr_en && r_page == 4'h4) ? r_wdata[3:0] : 4'h0;

  always_ff @(posedge Clock) begin
    if (Reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_edge_clr) | w_key_press;
  end

  // NOTE: the segment array drives outputs directly, so every entry is reset, not just the LEDs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ledr <= '0;
      for (int i = 0; i < 6; i++) r_seg[i] <= '0;
    end else if (w_wr_en) begin
      if (r_page == 4'h1) r_ledr <= r_wdata[LED_W-1:0];
      if (r_page == 4'h2) begin
        for (int i = 0; i < 6; i++) begin
          if (r_sel == 3'(i)) r_seg[i] <= r_wdata[6:0];
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (r_page)
      4'h1: w_rd_val = DATA_W'(r_ledr);
      4'h2: begin
        for (int i = 0; i < 6; i++) begin
          if (r_sel == 3'(i)) w_rd_val = DATA_W'(r_seg[i]);
        end
      end
      4'h3: w_rd_val = DATA_W'(r_sw_sync);
      4'h4: w_rd_val = DATA_W'(r_edge);
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ack      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ack      <= (r_state == BUSY);
      r_rd_valid <= w_rd_en;
      r_rdata    <= w_rd_en ? w_rd_val : '0;
    end
  end

  assign Ack     = r_ack;
  assign RdValid = r_rd_valid;
  assign RdData  = r_rdata;
  assign LEDR    = r_ledr;
  assign HEX0    = ~r_seg[0];
  assign HEX1    = ~r_seg[1];
  assign HEX2    = ~r_seg[2];
  assign HEX3    = ~r_seg[3];
  assign HEX4    = ~r_seg[4];
  assign HEX5    = ~r_seg[5];

  // Address and data bits outside the decoded fields are intentionally ignored.
  assign w_unused = ^{Addr, WrData, r_wdata};

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed scenarios plus a randomized
// access stream compared against a register-map model.
module tb_io_bus_responder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] WrData = '0;
  logic        Ack;
  logic        RdValid;
  logic [15:0] RdData;
  logic [9:0]  SW = '0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int errors = 0;
  int checks = 0;

  logic [9:0] m_led;
  logic [6:0] m_seg [6];
  logic [3:0] m_edge;
  logic [9:0] m_sw;
  logic [3:0] m_key;

  io_bus_responder #(.DATA_W(16), .SW_W(10), .LED_W(10)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WrData(WrData),
    .Ack(Ack), .RdValid(RdValid), .RdData(RdData), .SW(SW), .KEY(KEY), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [41:0] dut_hex();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [41:0] model_hex();
    return ~{m_seg[5], m_seg[4], m_seg[3], m_seg[2], m_seg[1], m_seg[0]};
  endfunction

  function automatic void model_reset();
    m_led  = '0;
    m_edge = '0;
    for (int i = 0; i < 6; i++) m_seg[i] = '0;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a[15:12] == 4'h1) v = {6'b0, m_led};
    if (a[15:12] == 4'h2 && a[2:0] < 3'd6) v = {9'b0, m_seg[a[2:0]]};
    if (a[15:12] == 4'h3) v = {6'b0, m_sw};
    if (a[15:12] == 4'h4) v = {12'b0, m_edge};
    return v;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
    if (a[15:12] == 4'h1) m_led = d[9:0];
    if (a[15:12] == 4'h2 && a[2:0] < 3'd6) m_seg[a[2:0]] = d[6:0];
    if (a[15:12] == 4'h4) m_edge = m_edge & ~d[3:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Drives one access from a negedge in IDLE and records outputs on the three following
  // negedges. Returns on the third, when the responder can accept the next request.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic hold_req,
                        output logic [2:0] ack_v, output logic [2:0] rv_v,
                        output logic [15:0] rd_n2, output logic [15:0] rd_other,
                        output logic [9:0] led_n1, output logic [9:0] led_n2,
                        output logic [41:0] hex_n2);
    Req = 1'b1; Wr = wr; Addr = a; WrData = d;
    @(posedge Clock); @(negedge Clock);
    Req = hold_req;
    if (!hold_req) begin
      Wr = 1'($urandom); Addr = 16'($urandom); WrData = 16'($urandom);
    end
    ack_v[0] = Ack; rv_v[0] = RdValid; rd_other = RdData; led_n1 = LEDR;
    @(posedge Clock); @(negedge Clock);
    Req = 1'b0;
    ack_v[1] = Ack; rv_v[1] = RdValid; rd_n2 = RdData; led_n2 = LEDR; hex_n2 = dut_hex();
    @(posedge Clock); @(negedge Clock);
    ack_v[2] = Ack; rv_v[2] = RdValid; rd_other = rd_other | RdData;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; KEY = 4'hF; SW = '0;
    m_key = 4'hF; m_sw = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checks++; if (LEDR !== 10'h000) begin errors++; $display("FAIL reset_ledr: got %h want 000", LEDR); end
    checks++; if (dut_hex() !== {6{7'h7F}}) begin errors++; $display("FAIL reset_hex: got %h want all 7F", dut_hex()); end
    checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", Ack); end
    checks++; if (RdValid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid: got %b want 0", RdValid); end
    checks++; if (RdData !== 16'h0000) begin errors++; $display("FAIL reset_rddata: got %h want 0000", RdData); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_led();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    access(1'b1, 16'h1000, 16'h02AA, 1'b0, av, rv, rd, ro, l1, l2, hx);
    model_write(16'h1000, 16'h02AA);
    checks++; if (av !== 3'b010) begin errors++; $display("FAIL led_wr_ack: got %b want 010", av); end
    checks++; if (rv !== 3'b000) begin errors++; $display("FAIL led_wr_rdvalid: got %b want 000", rv); end
    checks++; if (l1 !== 10'h000) begin errors++; $display("FAIL led_wr_early: got %h want 000", l1); end
    checks++; if (l2 !== 10'h2AA) begin errors++; $display("FAIL led_wr_value: got %h want 2AA", l2); end
    access(1'b0, 16'h1000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rv !== 3'b010) begin errors++; $display("FAIL led_rd_rdvalid: got %b want 010", rv); end
    checks++; if (rd !== 16'h02AA) begin errors++; $display("FAIL led_rd_data: got %h want 02AA", rd); end
    checks++; if (ro !== 16'h0000) begin errors++; $display("FAIL led_rd_idle_data: got %h want 0000", ro); end
  endtask

  task automatic test_hex();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    logic [41:0] want;
    access(1'b1, 16'h2003, 16'h0040, 1'b0, av, rv, rd, ro, l1, l2, hx);
    model_write(16'h2003, 16'h0040);
    want = {7'h7F, 7'h7F, 7'h3F, 7'h7F, 7'h7F, 7'h7F};
    checks++; if (hx !== want) begin errors++; $display("FAIL hex3_write: got %h want %h", hx, want); end
    access(1'b1, 16'h2007, 16'h007F, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (av !== 3'b010) begin errors++; $display("FAIL hex7_ack: got %b want 010", av); end
    checks++; if (hx !== want) begin errors++; $display("FAIL hex7_nochange: got %h want %h", hx, want); end
    access(1'b0, 16'h2003, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0040) begin errors++; $display("FAIL hex3_read: got %h want 0040", rd); end
    access(1'b0, 16'h2006, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if ({av, rv, rd} !== {3'b010, 3'b010, 16'h0000}) begin
      errors++; $display("FAIL hex6_read: got ack=%b rv=%b data=%h want 010 010 0000", av, rv, rd);
    end
    access(1'b0, 16'h7123, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if ({av, rv, rd} !== {3'b010, 3'b010, 16'h0000}) begin
      errors++; $display("FAIL unmapped_read: got ack=%b rv=%b data=%h want 010 010 0000", av, rv, rd);
    end
  endtask

  task automatic test_sw();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    SW = 10'h155; m_sw = 10'h155;
    wait_cycles(3);
    access(1'b0, 16'h3000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if ({av, rv} !== {3'b010, 3'b010}) begin errors++; $display("FAIL sw_strobes: got ack=%b rv=%b want 010 010", av, rv); end
    checks++; if (rd !== 16'h0155) begin errors++; $display("FAIL sw_read: got %h want 0155", rd); end
    access(1'b1, 16'h3000, 16'hFFFF, 1'b0, av, rv, rd, ro, l1, l2, hx);
    access(1'b0, 16'h3000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0155) begin errors++; $display("FAIL sw_write_ignored: got %h want 0155", rd); end
  endtask

  task automatic test_key();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    KEY = 4'b1101; wait_cycles(4);
    KEY = 4'b1111; wait_cycles(4);
    access(1'b0, 16'h4000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL key_press: got %h want 0002", rd); end
    access(1'b1, 16'h4000, 16'h0002, 1'b0, av, rv, rd, ro, l1, l2, hx);
    access(1'b0, 16'h4000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL key_clear: got %h want 0000", rd); end
    // Press lands in the synchronized domain on the same edge the clear commits.
    KEY = 4'b1101;
    @(posedge Clock); @(negedge Clock);
    access(1'b1, 16'h4000, 16'h000F, 1'b0, av, rv, rd, ro, l1, l2, hx);
    access(1'b0, 16'h4000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL key_set_wins: got %h want 0002", rd); end
    KEY = 4'b1111; wait_cycles(4);
    access(1'b0, 16'h4000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL key_release_no_edge: got %h want 0002", rd); end
    m_key = 4'hF; m_edge = 4'h2;
  endtask

  task automatic test_abort();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    Reset = 1'b1; wait_cycles(2); Reset = 1'b0;
    model_reset();
    Req = 1'b1; Wr = 1'b1; Addr = 16'h1000; WrData = 16'h03FF;
    @(posedge Clock); @(negedge Clock);
    Req = 1'b0; Reset = 1'b1;
    @(posedge Clock); @(negedge Clock);
    checks++; if ({Ack, RdValid} !== 2'b00) begin errors++; $display("FAIL abort_ack1: got %b want 00", {Ack, RdValid}); end
    checks++; if (LEDR !== 10'h000) begin errors++; $display("FAIL abort_led1: got %h want 000", LEDR); end
    Reset = 1'b0;
    @(posedge Clock); @(negedge Clock);
    checks++; if ({Ack, LEDR} !== 11'h000) begin errors++; $display("FAIL abort_after: got ack=%b led=%h want 0 000", Ack, LEDR); end
    access(1'b0, 16'h1000, 16'h0000, 1'b0, av, rv, rd, ro, l1, l2, hx);
    checks++; if ({av, rd} !== {3'b010, 16'h0000}) begin
      errors++; $display("FAIL abort_idle_access: got ack=%b data=%h want 010 0000", av, rd);
    end
    wait_cycles(3);
  endtask

  task automatic test_back_to_back();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    access(1'b1, 16'h1000, 16'h0123, 1'b1, av, rv, rd, ro, l1, l2, hx);
    model_write(16'h1000, 16'h0123);
    access(1'b0, 16'h1000, 16'h0000, 1'b1, av, rv, rd, ro, l1, l2, hx);
    checks++; if ({av, rv, rd} !== {3'b010, 3'b010, 16'h0123}) begin
      errors++; $display("FAIL b2b_read: got ack=%b rv=%b data=%h want 010 010 0123", av, rv, rd);
    end
  endtask

  task automatic test_random();
    logic [2:0] av, rv; logic [15:0] rd, ro; logic [9:0] l1, l2; logic [41:0] hx;
    logic [15:0] a, d, exp_rd; logic [9:0] led_old; logic wr; logic [3:0] page, k;
    bit changed;
    for (int n = 0; n < 80; n++) begin
      changed = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        SW = 10'($urandom); m_sw = SW; changed = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        k = 4'($urandom);
        m_edge = m_edge | (m_key & ~k);
        m_key = k; KEY = k; changed = 1'b1;
      end
      if (changed) wait_cycles(4);
      page = ($urandom_range(0, 5) == 5) ? 4'($urandom) : 4'($urandom_range(1, 4));
      a = {page, 12'($urandom)};
      d = 16'($urandom);
      wr = 1'($urandom);
      exp_rd = wr ? 16'h0000 : model_read(a);
      led_old = m_led;
      access(wr, a, d, 1'($urandom), av, rv, rd, ro, l1, l2, hx);
      if (wr) model_write(a, d);
      checks++; if (av !== 3'b010) begin errors++; $display("FAIL rnd_ack[%0d]: got %b want 010", n, av); end
      checks++; if (rv !== (wr ? 3'b000 : 3'b010)) begin errors++; $display("FAIL rnd_rdvalid[%0d]: got %b wr=%b", n, rv, wr); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rddata[%0d] addr=%h: got %h want %h", n, a, rd, exp_rd); end
      checks++; if (ro !== 16'h0000) begin errors++; $display("FAIL rnd_rddata_idle[%0d]: got %h want 0000", n, ro); end
      checks++; if (l1 !== led_old) begin errors++; $display("FAIL rnd_led_early[%0d]: got %h want %h", n, l1, led_old); end
      checks++; if (l2 !== m_led) begin errors++; $display("FAIL rnd_led[%0d] addr=%h: got %h want %h", n, a, l2, m_led); end
      checks++; if (hx !== model_hex()) begin errors++; $display("FAIL rnd_hex[%0d] addr=%h: got %h want %h", n, a, hx, model_hex()); end
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_hex();
    test_sw();
    test_key();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
